// File: rtl/main_mem_responder_pkg.sv
// Shared definitions for the cache-to-memory bus responder.
package mem_bus_pkg;

   // Default bus widths
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // Latency counter width; covers LATENCY 1..15
   localparam int CNT_W = 4;

   typedef logic [CNT_W-1:0] cnt_t;

   // Responder FSM encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-to-memory bus: request from the cache controller, completion from memory.
interface main_mem_responder_if
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic              bus_access;
   logic              write_opn_to_bus;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              finish;
   logic [DATA_W-1:0] out_data_Mem;
   logic              mem_busy;

   modport master (
      output bus_access, write_opn_to_bus, mem_address, mem_data,
      input  finish, out_data_Mem, mem_busy
   );

   modport slave (
      input  bus_access, write_opn_to_bus, mem_address, mem_data,
      output finish, out_data_Mem, mem_busy
   );

endinterface

// File: rtl/main_mem_responder_mem_array.sv
// Single-port synchronous RAM with registered read; contents are never reset.
module mem_array
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] store [2**ADDR_W];

   // Write on we, registered read on re (one-cycle read latency)
   always_ff @(posedge clk) begin
      if (we)
         store[addr] <= wdata;
      if (re)
         rdata <= store[addr];
   end

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: accepts one bus request, services it against the
// backing store after LATENCY cycles and returns a one-cycle finish pulse.
module main_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   main_mem_responder_if.slave  bus
);

   logic [1:0]        state;
   cnt_t              cnt;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              finish_q;
   logic [DATA_W-1:0] rdata_q;
   logic              busy_q;

   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   // RAM control: the read is issued one edge before DONE so its data is
   // ready on the DONE edge; with LATENCY=1 that edge is the acceptance edge,
   // hence the address comes straight from the bus while IDLE. Writes land on
   // the DONE edge and are gated by rst so a reset drops a pending write.
   always_comb begin
      ram_addr = (state == S_IDLE) ? bus.mem_address : addr_q;
      ram_we   = !rst && (state == S_WAIT) && (cnt == '0) && wr_q;
      ram_re   = !rst && (((state == S_IDLE) && (bus.bus_access == 1'b1) && (LATENCY == 1)) ||
                          ((state == S_WAIT) && (cnt == cnt_t'(1))));
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (data_q),
      .rdata (ram_rdata)
   );

   // Request FSM: latch on acceptance, count down, pulse finish, wait for release
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         finish_q <= 1'b0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               finish_q <= 1'b0;
               if (bus.bus_access == 1'b1) begin
                  wr_q   <= bus.write_opn_to_bus;
                  addr_q <= bus.mem_address;
                  data_q <= bus.mem_data;
                  cnt    <= cnt_t'(LATENCY - 1);
                  busy_q <= 1'b1;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0) begin
                  state    <= S_DONE;
                  finish_q <= 1'b1;
                  if (!wr_q)
                     rdata_q <= ram_rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               finish_q <= 1'b0;
               state    <= S_REL;
            end
            S_REL: begin
               if (bus.bus_access == 1'b0) begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.finish       = finish_q;
   assign bus.out_data_Mem = rdata_q;
   assign bus.mem_busy     = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_main_mem_responder;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   main_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
   main_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

   main_mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(4)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   main_mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to measure acceptance spacing
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int which, input logic acc, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
      if (which == 0) begin
         ifa.bus_access = acc; ifa.write_opn_to_bus = wr; ifa.mem_address = a; ifa.mem_data = d;
      end else begin
         ifb.bus_access = acc; ifb.write_opn_to_bus = wr; ifb.mem_address = a; ifb.mem_data = d;
      end
   endtask

   function automatic logic get_fin(input int which);
      return (which == 0) ? ifa.finish : ifb.finish;
   endfunction

   function automatic logic get_busy(input int which);
      return (which == 0) ? ifa.mem_busy : ifb.mem_busy;
   endfunction

   function automatic logic [7:0] get_out(input int which);
      return (which == 0) ? ifa.out_data_Mem : ifb.out_data_Mem;
   endfunction

   // Full transaction: accept, measure latency, check pulse width, release
   task automatic xact(input int which, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, input int lat_exp, input string tag,
                       output int acc_cyc);
      int n;
      drive(which, 1'b1, wr, a, d);
      step();
      acc_cyc = cyc;
      check({tag, "_busy"}, 32'(get_busy(which)), 32'd1);
      n = 0;
      while (get_fin(which) !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check({tag, "_lat"}, n, lat_exp);
      drive(which, 1'b0, wr, a, d);
      step();
      check({tag, "_width"}, 32'(get_fin(which)), 32'd0);
      step();
      check({tag, "_idle"}, 32'(get_busy(which)), 32'd0);
   endtask

   initial begin
      int acc0, acc1, n;

      // Reset with undefined address/data on both buses
      rst = 1'b1;
      ifa.bus_access = 1'b0;
      ifb.bus_access = 1'b0;
      repeat (3) step();
      check("rst_fin_a",  32'(ifa.finish),       32'd0);
      check("rst_busy_a", 32'(ifa.mem_busy),     32'd0);
      check("rst_out_a",  32'(ifa.out_data_Mem), 32'd0);
      check("rst_fin_b",  32'(ifb.finish),       32'd0);
      rst = 1'b0;

      // 1: idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         step();
         check("t1_fin",  32'(ifa.finish),       32'd0);
         check("t1_busy", 32'(ifa.mem_busy),     32'd0);
         check("t1_out",  32'(ifa.out_data_Mem), 32'd0);
         check("t1_fin_b", 32'(ifb.finish),      32'd0);
      end

      // 2: write A5 to 3C, read it back
      xact(0, 1'b1, 8'h3C, 8'hA5, 4, "t2w", acc0);
      check("t2w_out_hold", 32'(ifa.out_data_Mem), 32'd0);
      xact(0, 1'b0, 8'h3C, 8'h00, 4, "t2r", acc0);
      check("t2r_data", 32'(ifa.out_data_Mem), 32'hA5);

      // 3: read with bus_access held 6 cycles past finish
      drive(0, 1'b1, 1'b0, 8'h3C, 8'h00);
      step();
      n = 0;
      while (ifa.finish !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("t3_lat", n, 4);
      for (int i = 0; i < 6; i++) begin
         step();
         check("t3_nofin", 32'(ifa.finish),   32'd0);
         check("t3_busy",  32'(ifa.mem_busy), 32'd1);
      end
      drive(0, 1'b0, 1'b0, 8'h3C, 8'h00);
      step();
      check("t3_idle", 32'(ifa.mem_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_quiet", 32'(ifa.finish), 32'd0);
      end
      check("t3_data", 32'(ifa.out_data_Mem), 32'hA5);

      // 4: inputs change during WAIT; original write must complete
      xact(0, 1'b1, 8'hFF, 8'h11, 4, "t4pre", acc0);
      drive(0, 1'b1, 1'b1, 8'h20, 8'hC3);
      step();
      drive(0, 1'b1, 1'b0, 8'hFF, 8'h00);
      n = 0;
      while (ifa.finish !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("t4_lat", n, 4);
      check("t4_out_hold", 32'(ifa.out_data_Mem), 32'hA5);
      drive(0, 1'b0, 1'b0, 8'hFF, 8'h00);
      repeat (2) step();
      check("t4_idle", 32'(ifa.mem_busy), 32'd0);
      xact(0, 1'b0, 8'h20, 8'h00, 4, "t4r20", acc0);
      check("t4_data20", 32'(ifa.out_data_Mem), 32'hC3);
      xact(0, 1'b0, 8'hFF, 8'h00, 4, "t4rff", acc0);
      check("t4_dataff", 32'(ifa.out_data_Mem), 32'h11);

      // 5: reset two cycles into a write of 77 to 10
      xact(0, 1'b1, 8'h10, 8'h5A, 4, "t5pre", acc0);
      drive(0, 1'b1, 1'b1, 8'h10, 8'h77);
      step();
      step();
      rst = 1'b1;
      drive(0, 1'b0, 1'b1, 8'h10, 8'h77);
      step();
      rst = 1'b0;
      check("t5_busy", 32'(ifa.mem_busy),     32'd0);
      check("t5_out",  32'(ifa.out_data_Mem), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_nofin", 32'(ifa.finish), 32'd0);
      end
      xact(0, 1'b0, 8'h10, 8'h00, 4, "t5r", acc0);
      check("t5_data", 32'(ifa.out_data_Mem), 32'h5A);

      // 6: back-to-back at LATENCY=1
      xact(1, 1'b1, 8'h00, 8'h12, 1, "t6w0", acc0);
      xact(1, 1'b1, 8'hFF, 8'h34, 1, "t6w1", acc1);
      check("t6_wperiod", acc1 - acc0, 4);
      xact(1, 1'b0, 8'h00, 8'h00, 1, "t6r0", acc0);
      check("t6_data00", 32'(ifb.out_data_Mem), 32'h12);
      xact(1, 1'b0, 8'hFF, 8'h00, 1, "t6r1", acc1);
      check("t6_dataff", 32'(ifb.out_data_Mem), 32'h34);
      check("t6_rperiod", acc1 - acc0, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
